// File: rtl/neureka_streamout_sequencer.sv
// Streamout sequencer: walks the active PE accumulators in ascending index
// order and holds each one's streamout enable for a programmed number of
// store_out beats. Outputs are decoded from registered state only.
module neureka_streamout_sequencer #(
  parameter int NR_PE      = 36,
  parameter int BEAT_CNT_W = 8,
  parameter int SEL_W      = $clog2(NR_PE)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [NR_PE-1:0]      pe_mask_i,
  input  logic [BEAT_CNT_W-1:0] nb_beats_i,
  input  logic                  beat_valid_i,
  input  logic                  beat_ready_i,
  output logic [NR_PE-1:0]      enable_accumulator_o,
  output logic [SEL_W-1:0]      pe_sel_o,
  output logic                  sel_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_e;

  state_e                state;
  logic [NR_PE-1:0]      rem_mask;
  logic [BEAT_CNT_W-1:0] beats;
  logic [BEAT_CNT_W-1:0] beat_cnt;
  logic [SEL_W-1:0]      pe_sel;

  logic [NR_PE-1:0]      sel_onehot;
  logic [NR_PE-1:0]      nxt_mask;
  logic                  beat;
  logic                  last_beat;

  // Lowest set bit wins; scanning downward lets the lowest index overwrite.
  function automatic logic [SEL_W-1:0] lowest_idx(input logic [NR_PE-1:0] m);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = NR_PE-1; i >= 0; i--)
      if (m[i]) idx = SEL_W'(i);
    return idx;
  endfunction

  // One-hot decode of the registered PE select, one comparator per PE.
  for (genvar i = 0; i < NR_PE; i++) begin : g_onehot
    assign sel_onehot[i] = (pe_sel == SEL_W'(i));
  end

  assign beat      = beat_valid_i & beat_ready_i;
  assign last_beat = (beat_cnt == beats - BEAT_CNT_W'(1));
  assign nxt_mask  = rem_mask & ~sel_onehot;

  // Sequencer FSM: start/degenerate-start, per-PE beat counting, PE hand-off.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state    <= IDLE;
      rem_mask <= '0;
      beats    <= '0;
      beat_cnt <= '0;
      pe_sel   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            if (pe_mask_i == '0 || nb_beats_i == '0) begin
              state <= DONE;
            end else begin
              state    <= STREAM;
              rem_mask <= pe_mask_i;
              beats    <= nb_beats_i;
              beat_cnt <= '0;
              pe_sel   <= lowest_idx(pe_mask_i);
            end
          end
        end
        STREAM: begin
          if (beat) begin
            if (last_beat) begin
              // Hand off straight to the next PE, no bubble cycle.
              if (nxt_mask != '0) begin
                rem_mask <= nxt_mask;
                pe_sel   <= lowest_idx(nxt_mask);
                beat_cnt <= '0;
              end else begin
                state <= DONE;
              end
            end else begin
              beat_cnt <= beat_cnt + BEAT_CNT_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign enable_accumulator_o = (state == STREAM) ? sel_onehot : '0;
  assign pe_sel_o             = pe_sel;
  assign sel_valid_o          = (state == STREAM);
  assign busy_o               = (state != IDLE);
  assign done_o               = (state == DONE);

endmodule

// File: tb/tb_neureka_streamout_sequencer.sv
// Bench for the streamout sequencer: a beat-list reference model (one queue
// entry per expected beat, tagged with its PE) is checked every cycle, plus
// directed cycle-count / beat-count / enable-coverage checks.
module tb_neureka_streamout_sequencer;

  localparam int NR_PE = 36;

  logic        clk = 1'b0;
  logic        rst, clr, start, bv, br;
  logic [35:0] mask;
  logic [7:0]  nb;
  logic [35:0] enable;
  logic [5:0]  pe_sel;
  logic        sel_valid, busy, done;

  neureka_streamout_sequencer #(.NR_PE(NR_PE), .BEAT_CNT_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .start_i(start),
    .pe_mask_i(mask), .nb_beats_i(nb),
    .beat_valid_i(bv), .beat_ready_i(br),
    .enable_accumulator_o(enable), .pe_sel_o(pe_sel),
    .sel_valid_o(sel_valid), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: queue of PE indices, one per outstanding beat.
  int q[$];
  int mode;      // 0 idle, 1 streaming, 2 done pulse
  bit sel_zero;  // pe_sel known to be 0 (after reset)

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    if (rst || clr) begin
      q.delete(); mode = 0; sel_zero = 1;
    end else begin
      case (mode)
        0: if (start) begin
             if (mask == 0 || nb == 0) mode = 2;
             else begin
               q.delete();
               for (int p = 0; p < NR_PE; p++)
                 if (mask[p]) for (int b = 0; b < nb; b++) q.push_back(p);
               mode = 1; sel_zero = 0;
             end
           end
        1: if (bv && br) begin
             void'(q.pop_front());
             if (q.size() == 0) mode = 2;
           end
        default: mode = 0;
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [63:0] exp_en;
    exp_en = (mode == 1) ? (64'd1 << q[0]) : 64'd0;
    chk("enable", 64'(enable), exp_en);
    chk("sel_valid", 64'(sel_valid), 64'(mode == 1));
    chk("busy", 64'(busy), 64'(mode != 0));
    chk("done", 64'(done), 64'(mode == 2));
    if (mode == 1) chk("pe_sel", 64'(pe_sel), 64'(q[0]));
    else if (sel_zero) chk("pe_sel_rst", 64'(pe_sel), 64'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Start a run and step until done_o; rmode 0 = ready high, 1 = toggle, 2 = random.
  task automatic run(input logic [35:0] m, input logic [7:0] n, input int rmode,
                     output int cyc_n, output int hs, output logic [35:0] eor);
    mask = m; nb = n; start = 1'b1; cyc_n = 0; hs = 0; eor = '0;
    for (int k = 0; k < 2000; k++) begin
      case (rmode)
        0:       begin bv = 1'b1; br = 1'b1; end
        1:       begin bv = 1'b1; br = (k % 2) == 1; end
        default: begin bv = 1'($urandom_range(0, 1)); br = 1'($urandom_range(0, 1)); end
      endcase
      if (sel_valid && bv && br) hs++;
      tick();
      start = 1'b0; cyc_n++;
      eor |= enable;
      if (done) break;
    end
    start = 1'b0;
    tick();  // back to idle
  endtask

  int          cn, hs;
  logic [35:0] eor;
  logic [35:0] rm;
  logic [7:0]  rn;
  bit          found;

  initial begin
    rst = 1'b1; clr = 1'b0; start = 1'b0; bv = 1'b0; br = 1'b0;
    mask = '0; nb = '0; mode = 0; sel_zero = 1;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);

    // Full mask, 2 beats, ready high: done in cycle 73
    run({36{1'b1}}, 8'd2, 0, cn, hs, eor);
    chk("full_done_cycle", 64'(cn), 64'd73);
    chk("full_beats", 64'(hs), 64'd72);
    chk("full_enable_cov", 64'(eor), 64'hF_FFFF_FFFF);

    // Mask 0x9, 3 beats, ready toggling
    run(36'h9, 8'd3, 1, cn, hs, eor);
    chk("m9_beats", 64'(hs), 64'd6);
    chk("m9_enable_cov", 64'(eor), 64'h9);

    // Degenerate starts, with handshakes present in DONE
    bv = 1'b1; br = 1'b1;
    run(36'hFF, 8'd0, 0, cn, hs, eor);
    chk("nb0_done_cycle", 64'(cn), 64'd1);
    chk("nb0_enable", 64'(eor), 64'd0);
    run(36'h0, 8'd5, 0, cn, hs, eor);
    chk("m0_done_cycle", 64'(cn), 64'd1);
    chk("m0_enable", 64'(eor), 64'd0);

    // start re-pulsed with a different mask mid-stream is ignored
    nb = 8'd2; bv = 1'b1; br = 1'b1; eor = '0; cn = 0;
    for (int k = 0; k < 100; k++) begin
      start = (k == 0) || (k == 3);
      mask  = (k >= 3) ? 36'hF : 36'hF0;
      tick();
      cn++;
      eor |= enable;
      if (done) break;
    end
    start = 1'b0;
    tick();
    chk("restart_enable_cov", 64'(eor), 64'hF0);
    chk("restart_done_cycle", 64'(cn), 64'd9);

    // rst, then clear, in the middle of PE5
    for (int r = 0; r < 2; r++) begin
      mask = {36{1'b1}}; nb = 8'd3; bv = 1'b1; br = 1'b1; found = 0;
      for (int k = 0; k < 100; k++) begin
        start = (k == 0);
        tick();
        if (sel_valid && pe_sel == 6'd5) begin found = 1; break; end
      end
      start = 1'b0;
      chk("reached_pe5", 64'(found), 64'd1);
      tick();
      if (r == 0) rst = 1'b1; else clr = 1'b1;
      tick();
      rst = 1'b0; clr = 1'b0;
      chk("abort_enable", 64'(enable), 64'd0);
      chk("abort_sel_valid", 64'(sel_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_pe_sel", 64'(pe_sel), 64'd0);
      run(36'h1, 8'd1, 0, cn, hs, eor);
      chk("after_abort_done_cycle", 64'(cn), 64'd2);
    end

    // Reset together with start: stays idle
    rst = 1'b1; start = 1'b1; mask = 36'h3; nb = 8'd1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 64'(busy), 64'd0);
    tick();

    // Handshakes while idle, then a run with random backpressure
    bv = 1'b1; br = 1'b1;
    repeat (5) tick();
    run(36'h3, 8'd4, 2, cn, hs, eor);
    chk("idle_hs_beats", 64'(hs), 64'd8);

    // Randomized runs
    for (int t = 0; t < 8; t++) begin
      rm = {4'($urandom), 32'($urandom)};
      if (t % 2 == 1) rm &= {4'($urandom), 32'($urandom)};
      rn = 8'($urandom_range(1, 4));
      run(rm, rn, 2, cn, hs, eor);
      chk("rand_beats", 64'(hs), 64'($countones(rm)) * 64'(rn));
      chk("rand_enable_cov", 64'(eor), 64'(rm));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/neureka_streamout_sequencer.md
# neureka_streamout_sequencer

Sequences the streamout phase of the NEUREKA engine. After a tile has been accumulated, it walks the active PE accumulators one at a time in ascending index order. For each one it asserts that accumulator's streamout enable and the serializer select for a programmed number of output beats. It sits between the tile controller and the engine's `enable_accumulator` and `ctrl_serialize_streamout` inputs, and counts completed beats by observing the `store_out` handshake.

## Interface
Parameters:
- `NR_PE`, default 36: number of PE accumulators (PE_H*PE_W).
- `BEAT_CNT_W`, default 8: width of the per-PE beat count.
- `SEL_W`, default $clog2(NR_PE): width of the PE select.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `clear_i`  in  1  soft clear; synchronous, same effect as `rst_i`.
- `start_i`  in  1  start-of-streamout pulse; sampled only in IDLE.
- `pe_mask_i`  in  NR_PE  active-PE mask; bit i=1 means PE i streams out. Latched on an accepted start.
- `nb_beats_i`  in  BEAT_CNT_W  beats per PE. Latched on an accepted start; 0 means nothing to stream.
- `beat_valid_i`  in  1  `store_out.valid` as seen by the sequencer.
- `beat_ready_i`  in  1  `store_out.ready` as seen by the sequencer.
- `enable_accumulator_o`  out  NR_PE  one-hot streamout enable; all zero outside STREAM.
- `pe_sel_o`  out  SEL_W  index of the PE currently streaming, driven to the serializer.
- `sel_valid_o`  out  1  `pe_sel_o` is meaningful; high exactly in STREAM.
- `busy_o`  out  1  high when state != IDLE.
- `done_o`  out  1  one-cycle pulse in DONE.

## Operation
- State machine states: IDLE, STREAM, DONE.
- Internal registers: `rem_mask` (NR_PE bits), `beats` (BEAT_CNT_W bits), `beat_cnt` (BEAT_CNT_W bits), `pe_sel` (SEL_W bits).
- Beat event: `beat_valid_i & beat_ready_i` while in STREAM. The same handshake in IDLE or DONE is ignored.
- Transitions out of IDLE, when `start_i`=1:
  - If `pe_mask_i`==0 or `nb_beats_i`==0: go to DONE.
  - Otherwise: go to STREAM and load `rem_mask`=`pe_mask_i`, `beats`=`nb_beats_i`, `beat_cnt`=0, and `pe_sel`=index of the lowest set bit of `pe_mask_i` (combinational priority encoder).
- In STREAM:
  - `enable_accumulator_o`=1<<`pe_sel`.
  - On a beat event with `beat_cnt`!=`beats`-1: `beat_cnt`++.
  - Last beat of the PE (beat event with `beat_cnt`==`beats`-1):
    - Compute `nxt` = `rem_mask` with bit `pe_sel` cleared.
    - If `nxt`!=0: `rem_mask`=`nxt`, `pe_sel`=lowest set bit of `nxt`, `beat_cnt`=0, stay in STREAM. There is no bubble cycle between PEs.
    - If `nxt`==0: go to DONE.
- DONE: `done_o`=1 for this cycle only, then go to IDLE unconditionally.
- `start_i` outside IDLE is ignored; no queuing, no error flag.
- Beat counter comparison is against `beats`-1 in BEAT_CNT_W bits. `beats`≥1 is guaranteed because a zero count is diverted to DONE at start, so no wrap-around case exists.
- `rst_i` or `clear_i` in any state, including mid-STREAM: next edge goes to IDLE and clears every register to 0. Beats already in flight in the serializer are the engine's concern (its clear flushes them).

## Timing
- Reset values: `enable_accumulator_o`=0, `pe_sel_o`=0, `sel_valid_o`=0, `busy_o`=0, `done_o`=0.
- All outputs are registered or decoded from registered state only. There is no combinational path from `beat_*_i` to any output.
- Start latency: `start_i` sampled at edge 0 → `enable_accumulator_o` valid in cycle 1.
- PE switch: the last beat of PE a, accepted at edge n, moves the enable to PE b in cycle n+1.
- Completion: the last beat at edge n → `done_o`=1 in cycle n+1, `busy_o`=0 in cycle n+2.
- Backpressure (`beat_ready_i`=0) holds all state; `enable_accumulator_o` stays stable.
- Throughput: one beat per cycle, so the total is popcount(mask)*beats cycles plus 1 cycle of start latency and 1 cycle of DONE.
- `rst_i` and `clear_i` asserted together with `start_i`: reset wins and the FSM stays in IDLE.

## Test plan
- Full mask (all 36 PEs), `nb_beats_i`=2, ready tied high, start at cycle 0:
  - PE i is enabled in cycles 2i+1 and 2i+2.
  - `done_o` in cycle 73; `busy_o` low from cycle 74.
- Mask 0x9 (PE0 and PE3), `nb_beats_i`=3, ready toggling 1,0,1,0,…:
  - PE3 is never skipped; PE1 and PE2 are never enabled.
  - `enable_accumulator_o` stays stable during ready=0 cycles.
  - Exactly 6 beats are counted before `done_o`.
- Degenerate starts, `nb_beats_i`=0 or `pe_mask_i`=0:
  - `done_o` in cycle 1 (the DONE cycle); `sel_valid_o` and `enable_accumulator_o` never asserted.
- `start_i` re-pulsed with a different mask mid-STREAM:
  - It is ignored; the original sequence completes unchanged.
- `rst_i` (then `clear_i` in a separate run) asserted in the middle of PE5's streamout:
  - All outputs are 0 at the next cycle.
  - A fresh start with mask 0x1 and 1 beat completes normally: `done_o` in cycle 2 with ready tied high.
- Beat handshakes injected while IDLE or DONE:
  - They do not affect `beat_cnt`; the following run produces exactly the programmed beat count.
